// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Constants and types shared by the CPU register file and its readback engine.
//   - state_t    : reg_dump_reader FSM encoding (IDLE, ISSUE, SEND, FINISH)
//   - NUM_REGS   : number of architectural registers
//   - REG_ADDR_W : register-file address width
//   - REG_DATA_W : register-file data width
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int NUM_REGS   = 32;
   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      SEND   = 2'd2,
      FINISH = 2'd3
   } state_t;

endpackage : cpu_pkg

// File: rtl/reg_dump_reader.sv
// -----------------------------------------------------------------------------
// reg_dump_reader
// Scans every register of the CPU register file through its single read port
// and streams each value out over a valid/ready interface. While a dump runs,
// BUSY stalls the CPU so the register contents stay frozen.
//
// Ports:
//   CLK      in   clock, all state changes on the rising edge
//   RESET    in   synchronous active-high reset (aborts a dump, no DONE)
//   START    in   one-cycle dump request, only honoured when idle
//   REGADDR  out  register-file read address (index in ISSUE/SEND, else 0)
//   REGDATA  in   register-file read data for REGADDR (combinational read)
//   DOUT     out  streamed register value
//   DADDR    out  register index carried on DOUT
//   DVALID   out  DOUT/DADDR valid
//   DREADY   in   consumer accepts the beat when high together with DVALID
//   BUSY     out  high whenever the engine is not idle (CPU stall)
//   DONE     out  one-cycle pulse after the last beat is accepted
// -----------------------------------------------------------------------------
module reg_dump_reader #(
   parameter int NUM_REGS   = cpu_pkg::NUM_REGS,
   parameter int ADDR_WIDTH = cpu_pkg::REG_ADDR_W,
   parameter int DATA_WIDTH = cpu_pkg::REG_DATA_W
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  START,
   output logic [ADDR_WIDTH-1:0] REGADDR,
   input  logic [DATA_WIDTH-1:0] REGDATA,
   output logic [DATA_WIDTH-1:0] DOUT,
   output logic [ADDR_WIDTH-1:0] DADDR,
   output logic                  DVALID,
   input  logic                  DREADY,
   output logic                  BUSY,
   output logic                  DONE
);

   import cpu_pkg::*;

   // Terminal index; compared before incrementing so the counter never wraps.
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
   localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1'b1);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [ADDR_WIDTH-1:0]   r_index;
   logic [ADDR_WIDTH-1:0]   w_index_nxt;
   logic                    w_load;
   logic                    w_handshake;

   logic [ADDR_WIDTH-1:0]   r_regaddr;
   logic [DATA_WIDTH-1:0]   r_dout;
   logic [ADDR_WIDTH-1:0]   r_daddr;
   logic                    r_dvalid;
   logic                    r_busy;
   logic                    r_done;

   // Next-state, next-index and capture-enable decode for the dump FSM.
   always_comb begin
      w_state_nxt = r_state;
      w_index_nxt = r_index;
      w_load      = 1'b0;
      // DREADY only matters while a beat is actually presented.
      w_handshake = (r_state == SEND) && DREADY;

      case (r_state)
         IDLE: begin
            if (START) begin
               w_state_nxt = ISSUE;
               w_index_nxt = {ADDR_WIDTH{1'b0}};
            end else begin
               w_state_nxt = IDLE;
            end
         end
         ISSUE: begin
            // One settle cycle for the combinational read, then capture.
            w_state_nxt = SEND;
            w_load      = 1'b1;
         end
         SEND: begin
            if (w_handshake) begin
               if (r_index == LAST_IDX) begin
                  w_state_nxt = FINISH;
               end else begin
                  w_state_nxt = ISSUE;
                  w_index_nxt = r_index + IDX_ONE;
               end
            end else begin
               w_state_nxt = SEND;
            end
         end
         FINISH: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
            w_index_nxt = {ADDR_WIDTH{1'b0}};
         end
      endcase
   end

   // State, index and output registers; outputs are derived from the next
   // state so they line up with the state they describe.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state   <= IDLE;
         r_index   <= {ADDR_WIDTH{1'b0}};
         r_regaddr <= {ADDR_WIDTH{1'b0}};
         r_dout    <= {DATA_WIDTH{1'b0}};
         r_daddr   <= {ADDR_WIDTH{1'b0}};
         r_dvalid  <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_index   <= w_index_nxt;
         r_regaddr <= ((w_state_nxt == ISSUE) || (w_state_nxt == SEND)) ?
                      w_index_nxt : {ADDR_WIDTH{1'b0}};
         if (w_load) begin
            r_dout  <= REGDATA;
            r_daddr <= r_index;
         end
         r_dvalid  <= (w_state_nxt == SEND);
         r_busy    <= (w_state_nxt != IDLE);
         r_done    <= (w_state_nxt == FINISH);
      end
   end

   assign REGADDR = r_regaddr;
   assign DOUT    = r_dout;
   assign DADDR   = r_daddr;
   assign DVALID  = r_dvalid;
   assign BUSY    = r_busy;
   assign DONE    = r_done;

endmodule : reg_dump_reader
